// File: rtl/tlul_pkg.sv
// Shared TileLink-UL opcodes, crossbar constants and small index helpers.
package tlul_pkg;

  localparam int unsigned N_MASTERS = 3;
  localparam int unsigned MIW       = 2;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  function automatic logic [2:0] err_d_opcode(logic [2:0] a_op);
    logic [2:0] d_op;
    d_op = (a_op == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
    return d_op;
  endfunction

  function automatic logic [1:0] inc_mod3(logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] onehot3_idx(logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/tlul_rr_arbiter.sv
// Three-requester arbiter with one-hot grant; round-robin when TLUL_XBAR_RR_ARB_EN is
// defined, fixed priority (0 > 1 > 2) otherwise. A stalled grant is held until it advances.
module tlul_rr_arbiter
  import tlul_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic       i_advance,
  output logic [2:0] o_gnt
);

  logic       r_lock;
  logic [2:0] r_lock_gnt;
  logic [2:0] w_pick;

`ifdef TLUL_XBAR_RR_ARB_EN
  logic [1:0] r_ptr;
  logic [1:0] w_i0, w_i1, w_i2;

  always_comb begin
    w_i0   = r_ptr;
    w_i1   = inc_mod3(w_i0);
    w_i2   = inc_mod3(w_i1);
    w_pick = 3'b000;
    if (i_req[w_i0])      w_pick[w_i0] = 1'b1;
    else if (i_req[w_i1]) w_pick[w_i1] = 1'b1;
    else if (i_req[w_i2]) w_pick[w_i2] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_ptr <= 2'd0;
    else if (i_advance) r_ptr <= inc_mod3(onehot3_idx(o_gnt));
  end
`else
  always_comb begin
    w_pick = 3'b000;
    if (i_req[0])      w_pick = 3'b001;
    else if (i_req[1]) w_pick = 3'b010;
    else if (i_req[2]) w_pick = 3'b100;
  end
`endif

  // A request left waiting keeps its grant even if a higher-ranked master shows up.
  assign o_gnt = (r_lock && |(i_req & r_lock_gnt)) ? r_lock_gnt : w_pick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lock     <= 1'b0;
      r_lock_gnt <= 3'b000;
    end else if (i_advance) begin
      r_lock     <= 1'b0;
    end else begin
      r_lock     <= |o_gnt;
      r_lock_gnt <= o_gnt;
    end
  end

endmodule

// File: rtl/tlul_xbar_3m1s.sv
// 3-master to 1-slave TL-UL crossbar with local error responder for out-of-window requests.
// Arbitration mode selected by macro TLUL_XBAR_RR_ARB_EN (round-robin) / fixed priority.
module tlul_xbar_3m1s
  import tlul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK = 32'hFFFF_F000,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3
) (
  input  logic                      clk_100,
  input  logic                      reset,
  input  logic [2:0]                master_a_valid,
  output logic [2:0]                master_a_ready,
  input  logic [3*OPCODE_WIDTH-1:0] master_a_opcode,
  input  logic [3*PARAM_WIDTH-1:0]  master_a_param,
  input  logic [3*SIZE_WIDTH-1:0]   master_a_size,
  input  logic [3*SRC_WIDTH-1:0]    master_a_source,
  input  logic [3*ADDR_WIDTH-1:0]   master_a_address,
  input  logic [3*MASK_WIDTH-1:0]   master_a_mask,
  input  logic [3*DATA_WIDTH-1:0]   master_a_data,
  output logic [2:0]                master_d_valid,
  input  logic [2:0]                master_d_ready,
  output logic [3*OPCODE_WIDTH-1:0] master_d_opcode,
  output logic [3*PARAM_WIDTH-1:0]  master_d_param,
  output logic [3*SIZE_WIDTH-1:0]   master_d_size,
  output logic [3*SRC_WIDTH-1:0]    master_d_source,
  output logic [3*SINK_WIDTH-1:0]   master_d_sink,
  output logic [3*DATA_WIDTH-1:0]   master_d_data,
  output logic [2:0]                master_d_error,
  output logic                      slave_a_valid,
  input  logic                      slave_a_ready,
  output logic [OPCODE_WIDTH-1:0]   slave_a_opcode,
  output logic [PARAM_WIDTH-1:0]    slave_a_param,
  output logic [SIZE_WIDTH-1:0]     slave_a_size,
  output logic [SRC_WIDTH+1:0]      slave_a_source,
  output logic [ADDR_WIDTH-1:0]     slave_a_address,
  output logic [MASK_WIDTH-1:0]     slave_a_mask,
  output logic [DATA_WIDTH-1:0]     slave_a_data,
  input  logic                      slave_d_valid,
  output logic                      slave_d_ready,
  input  logic [OPCODE_WIDTH-1:0]   slave_d_opcode,
  input  logic [PARAM_WIDTH-1:0]    slave_d_param,
  input  logic [SIZE_WIDTH-1:0]     slave_d_size,
  input  logic [SRC_WIDTH+1:0]      slave_d_source,
  input  logic [SINK_WIDTH-1:0]     slave_d_sink,
  input  logic [DATA_WIDTH-1:0]     slave_d_data,
  input  logic                      slave_d_error
);

  logic [2:0]              w_gnt;
  logic [1:0]              w_g;
  logic                    w_req_vld, w_hit, w_a_fire, w_err_fire;
  logic [OPCODE_WIDTH-1:0] w_a_opcode;
  logic [SIZE_WIDTH-1:0]   w_a_size;
  logic [SRC_WIDTH-1:0]    w_a_source;
  logic [1:0]              w_t;

  logic                    r_err_vld;
  logic [1:0]              r_err_idx;
  logic [OPCODE_WIDTH-1:0] r_err_op;
  logic [SIZE_WIDTH-1:0]   r_err_size;
  logic [SRC_WIDTH-1:0]    r_err_src;

  tlul_rr_arbiter u_arb (
    .i_clk     (clk_100),
    .i_rst_n   (reset),
    .i_req     (master_a_valid),
    .i_advance (w_a_fire),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_g             = 2'd0;
    w_a_opcode      = '0;
    w_a_size        = '0;
    w_a_source      = '0;
    slave_a_param   = '0;
    slave_a_address = '0;
    slave_a_mask    = '0;
    slave_a_data    = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_gnt[i]) begin
        w_g             = 2'(i);
        w_a_opcode      = master_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        w_a_size        = master_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        w_a_source      = master_a_source[i*SRC_WIDTH +: SRC_WIDTH];
        slave_a_param   = master_a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
        slave_a_address = master_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        slave_a_mask    = master_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
        slave_a_data    = master_a_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_req_vld      = reset && (|w_gnt);
  assign w_hit          = (slave_a_address & SLAVE_MASK) == SLAVE_BASE;
  assign w_a_fire       = w_req_vld && (w_hit ? slave_a_ready : !r_err_vld);
  assign slave_a_valid  = w_req_vld && w_hit;
  assign slave_a_opcode = w_a_opcode;
  assign slave_a_size   = w_a_size;
  assign slave_a_source = {w_g, w_a_source};
  assign master_a_ready = w_a_fire ? w_gnt : 3'b000;

  assign w_t = slave_d_source[SRC_WIDTH +: 2];

  always_comb begin
    master_d_valid  = '0;
    master_d_opcode = '0;
    master_d_param  = '0;
    master_d_size   = '0;
    master_d_source = '0;
    master_d_sink   = '0;
    master_d_data   = '0;
    master_d_error  = '0;
    w_err_fire      = 1'b0;
    unique case (w_t)
      2'd0:    slave_d_ready = reset && master_d_ready[0];
      2'd1:    slave_d_ready = reset && master_d_ready[1];
      2'd2:    slave_d_ready = reset && master_d_ready[2];
      default: slave_d_ready = reset;
    endcase
    for (int i = 0; i < 3; i++) begin
      // Slave beats win; the error slot only drives a master the slave is not targeting.
      if (reset && slave_d_valid && w_t == 2'(i)) begin
        master_d_valid[i]                                = 1'b1;
        master_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = slave_d_opcode;
        master_d_param[i*PARAM_WIDTH +: PARAM_WIDTH]    = slave_d_param;
        master_d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = slave_d_size;
        master_d_source[i*SRC_WIDTH +: SRC_WIDTH]       = slave_d_source[SRC_WIDTH-1:0];
        master_d_sink[i*SINK_WIDTH +: SINK_WIDTH]       = slave_d_sink;
        master_d_data[i*DATA_WIDTH +: DATA_WIDTH]       = slave_d_data;
        master_d_error[i]                               = slave_d_error;
      end else if (reset && r_err_vld && r_err_idx == 2'(i)) begin
        master_d_valid[i]                                = 1'b1;
        master_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = r_err_op;
        master_d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = r_err_size;
        master_d_source[i*SRC_WIDTH +: SRC_WIDTH]       = r_err_src;
        master_d_error[i]                               = 1'b1;
        w_err_fire                                      = master_d_ready[i];
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (!reset) begin
      r_err_vld  <= 1'b0;
      r_err_idx  <= 2'd0;
      r_err_op   <= '0;
      r_err_size <= '0;
      r_err_src  <= '0;
    end else if (w_err_fire) begin
      r_err_vld  <= 1'b0;
    end else if (w_a_fire && !w_hit) begin
      r_err_vld  <= 1'b1;
      r_err_idx  <= w_g;
      r_err_op   <= OPCODE_WIDTH'(err_d_opcode(3'(w_a_opcode)));
      r_err_size <= w_a_size;
      r_err_src  <= w_a_source;
    end
  end

endmodule

// File: tb/tb_tlul_xbar_3m1s.sv
// Randomized self-checking bench for tlul_xbar_3m1s with a behavioural crossbar model.
module tb_tlul_xbar_3m1s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_a_valid, m_a_ready;
  logic [8:0]  m_a_opcode, m_a_param, m_a_size;
  logic [5:0]  m_a_source;
  logic [95:0] m_a_address, m_a_data;
  logic [11:0] m_a_mask;
  logic [2:0]  m_d_valid, m_d_ready, m_d_sink, m_d_error;
  logic [8:0]  m_d_opcode, m_d_param, m_d_size;
  logic [5:0]  m_d_source;
  logic [95:0] m_d_data;
  logic        s_a_valid, s_a_ready;
  logic [2:0]  s_a_opcode, s_a_param, s_a_size;
  logic [3:0]  s_a_source;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;
  logic        s_d_valid, s_d_ready, s_d_sink, s_d_error;
  logic [2:0]  s_d_opcode, s_d_param, s_d_size;
  logic [3:0]  s_d_source;
  logic [31:0] s_d_data;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  tlul_xbar_3m1s dut (
    .clk_100(clk), .reset(rst_n),
    .master_a_valid(m_a_valid), .master_a_ready(m_a_ready), .master_a_opcode(m_a_opcode),
    .master_a_param(m_a_param), .master_a_size(m_a_size), .master_a_source(m_a_source),
    .master_a_address(m_a_address), .master_a_mask(m_a_mask), .master_a_data(m_a_data),
    .master_d_valid(m_d_valid), .master_d_ready(m_d_ready), .master_d_opcode(m_d_opcode),
    .master_d_param(m_d_param), .master_d_size(m_d_size), .master_d_source(m_d_source),
    .master_d_sink(m_d_sink), .master_d_data(m_d_data), .master_d_error(m_d_error),
    .slave_a_valid(s_a_valid), .slave_a_ready(s_a_ready), .slave_a_opcode(s_a_opcode),
    .slave_a_param(s_a_param), .slave_a_size(s_a_size), .slave_a_source(s_a_source),
    .slave_a_address(s_a_address), .slave_a_mask(s_a_mask), .slave_a_data(s_a_data),
    .slave_d_valid(s_d_valid), .slave_d_ready(s_d_ready), .slave_d_opcode(s_d_opcode),
    .slave_d_param(s_d_param), .slave_d_size(s_d_size), .slave_d_source(s_d_source),
    .slave_d_sink(s_d_sink), .slave_d_data(s_d_data), .slave_d_error(s_d_error)
  );

  // Arbitration rule: first valid master starting at the pointer (RR) or at master 0.
  function automatic int exp_grant(logic [2:0] v);
`ifdef TLUL_XBAR_RR_ARB_EN
    for (int k = 0; k < 3; k++) if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] hit_addr();
    return {20'h0, 12'($urandom)};
  endfunction

  function automatic logic [31:0] miss_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:12] == 20'h0) a[12] = 1'b1;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '0; s_a_ready = 1'b0;
    s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
    s_d_sink = 1'b0; s_d_data = '0; s_d_error = 1'b0;
  endtask

  task automatic set_a(input int m, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] dat, input logic [1:0] src);
    m_a_valid[m]            = 1'b1;
    m_a_opcode[m*3 +: 3]    = op;
    m_a_size[m*3 +: 3]      = 3'd2;
    m_a_source[m*2 +: 2]    = src;
    m_a_address[m*32 +: 32] = addr;
    m_a_mask[m*4 +: 4]      = 4'hF;
    m_a_data[m*32 +: 32]    = dat;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    settle();
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    set_a(0, 3'd4, 32'h0, 32'h0, 2'd0);
    set_a(1, 3'd4, 32'h5000, 32'h0, 2'd0);
    s_a_ready = 1'b1; s_d_valid = 1'b1; m_d_ready = 3'b111;
    settle();
    checks++;
    if ({s_a_valid, m_a_ready, m_d_valid, s_d_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_gating: got %b exp 00000000", {s_a_valid, m_a_ready, m_d_valid, s_d_ready});
    end
    tick();
    apply_reset();
    checks++;
    if ({s_a_valid, m_a_ready, m_d_valid} !== 7'h00) begin
      errors++;
      $display("FAIL reset_idle: got %b exp 0000000", {s_a_valid, m_a_ready, m_d_valid});
    end
  endtask

  task automatic test_get_miss();
    clear_inputs();
    set_a(0, 3'd4, 32'h1000, 32'h0, 2'd2);
    settle();
    checks++;
    if (m_a_ready !== 3'b001 || s_a_valid !== 1'b0) begin
      errors++;
      $display("FAIL get_miss_accept: ready %b slave_valid %b exp 001/0", m_a_ready, s_a_valid);
    end
    tick();
    m_ptr = 1;
    clear_inputs();
    settle();
    checks++;
    if (m_d_valid !== 3'b001 || m_d_opcode[2:0] !== 3'd1 || m_d_source[1:0] !== 2'd2 ||
        m_d_error !== 3'b001 || m_d_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL get_miss_resp: v %b op %0d src %0d err %b data %h", m_d_valid,
               m_d_opcode[2:0], m_d_source[1:0], m_d_error, m_d_data[31:0]);
    end
    m_d_ready = 3'b001;
    tick();
    clear_inputs();
    settle();
    checks++;
    if (m_d_valid !== 3'b000) begin
      errors++;
      $display("FAIL get_miss_drain: got %b exp 000", m_d_valid);
    end
  endtask

  task automatic test_put_hit();
    clear_inputs();
    set_a(1, 3'd0, 32'h0000_0020, 32'hCAFEBABE, 2'd1);
    s_a_ready = 1'b1;
    settle();
    checks++;
    if (s_a_valid !== 1'b1 || s_a_source !== 4'b0101 || s_a_data !== 32'hCAFEBABE ||
        s_a_address !== 32'h20 || m_a_ready !== 3'b010) begin
      errors++;
      $display("FAIL put_hit_a: v %b src %b data %h ready %b", s_a_valid, s_a_source, s_a_data,
               m_a_ready);
    end
    tick();
    m_ptr = 2;
    clear_inputs();
    s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_source = 4'b0101; m_d_ready = 3'b010;
    settle();
    checks++;
    if (m_d_valid !== 3'b010 || m_d_source[3:2] !== 2'd1 || m_d_opcode[5:3] !== 3'd0 ||
        s_d_ready !== 1'b1 || m_d_error !== 3'b000) begin
      errors++;
      $display("FAIL put_hit_d: v %b src %0d op %0d sready %b", m_d_valid, m_d_source[3:2],
               m_d_opcode[5:3], s_d_ready);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    int g;
    apply_reset();
    for (int i = 0; i < 3; i++) set_a(i, 3'd4, 32'h100 + 32'(i), 32'h0, 2'(i));
    s_a_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      g = exp_grant(3'b111);
      checks++;
      if (int'(s_a_source[3:2]) != g || m_a_ready !== 3'(1 << g)) begin
        errors++;
        $display("FAIL contention_c%0d: grant %0d ready %b exp %0d", c, s_a_source[3:2],
                 m_a_ready, g);
      end
      tick();
      m_ptr = (g + 1) % 3;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    set_a(2, 3'd1, 32'h40, 32'h1234_5678, 2'd3);
    settle();
    checks++;
    if (s_a_source !== 4'b1011 || m_a_ready !== 3'b000 || s_a_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_initial: src %b ready %b exp 1011/000", s_a_source, m_a_ready);
    end
    tick();
    set_a(0, 3'd4, 32'h80, 32'h0, 2'd0);
    set_a(1, 3'd4, 32'h90, 32'h0, 2'd1);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (s_a_source !== 4'b1011 || s_a_address !== 32'h40 || s_a_data !== 32'h1234_5678 ||
          m_a_ready !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold_c%0d: src %b addr %h ready %b", c, s_a_source, s_a_address,
                 m_a_ready);
      end
      tick();
    end
    s_a_ready = 1'b1;
    settle();
    checks++;
    if (m_a_ready !== 3'b100) begin
      errors++;
      $display("FAIL bp_release: got %b exp 100", m_a_ready);
    end
    tick();
    m_ptr = 0;
    m_a_valid[2] = 1'b0;
    settle();
    checks++;
    if (int'(s_a_source[3:2]) != exp_grant(3'b011)) begin
      errors++;
      $display("FAIL bp_next: got %0d exp %0d", s_a_source[3:2], exp_grant(3'b011));
    end
    tick();
    m_ptr = (exp_grant(3'b011) + 1) % 3;
    clear_inputs();
  endtask

  task automatic test_d_collision();
    logic [31:0] dat;
    apply_reset();
    set_a(2, 3'd4, 32'h2000, 32'h0, 2'd3);
    tick();
    m_ptr = 0;
    clear_inputs();
    dat = $urandom;
    s_d_valid = 1'b1; s_d_source = 4'b1001; s_d_data = dat; s_d_opcode = 3'd1;
    m_d_ready = 3'b100;
    settle();
    checks++;
    if (m_d_valid !== 3'b100 || m_d_data[64 +: 32] !== dat || m_d_error[2] !== 1'b0 ||
        m_d_source[5:4] !== 2'd1 || s_d_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_slave_first: v %b data %h err %b src %0d", m_d_valid,
               m_d_data[64 +: 32], m_d_error, m_d_source[5:4]);
    end
    tick();
    s_d_valid = 1'b0;
    settle();
    checks++;
    if (m_d_valid !== 3'b100 || m_d_error !== 3'b100 || m_d_opcode[8:6] !== 3'd1 ||
        m_d_source[5:4] !== 2'd3) begin
      errors++;
      $display("FAIL coll_err_after: v %b err %b op %0d src %0d", m_d_valid, m_d_error,
               m_d_opcode[8:6], m_d_source[5:4]);
    end
    tick();
    clear_inputs();
    s_d_valid = 1'b1; s_d_source = 4'b1100;
    settle();
    checks++;
    if (s_d_ready !== 1'b1 || m_d_valid !== 3'b000) begin
      errors++;
      $display("FAIL tag3_drop: sready %b v %b exp 1/000", s_d_ready, m_d_valid);
    end
    clear_inputs();
    set_a(0, 3'd0, 32'hF000_0000, 32'h0, 2'd1);
    tick();
    clear_inputs();
    s_d_valid = 1'b1; s_d_source = 4'b0110;
    settle();
    checks++;
    if (m_d_valid !== 3'b011 || m_d_error !== 3'b001 || m_d_opcode[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL dual_target: v %b err %b exp 011/001", m_d_valid, m_d_error);
    end
    m_d_ready = 3'b011;
    tick();
    clear_inputs();
  endtask

  task automatic test_midop_reset();
    apply_reset();
    set_a(1, 3'd4, 32'h8000_0000, 32'h0, 2'd2);
    tick();
    clear_inputs();
    settle();
    checks++;
    if (m_d_valid !== 3'b010) begin
      errors++;
      $display("FAIL midrst_full: got %b exp 010", m_d_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    settle();
    checks++;
    if (m_d_valid !== 3'b000 || s_a_valid !== 1'b0 || m_a_ready !== 3'b000) begin
      errors++;
      $display("FAIL midrst_empty: d %b sa %b ar %b exp 0", m_d_valid, s_a_valid, m_a_ready);
    end
  endtask

  task automatic test_random();
    int m, t;
    logic hit;
    logic [2:0] op, exp_op;
    logic [31:0] addr, dat;
    logic [1:0] src;
    logic [2:0] rdy, exp_v;
    logic exp_sr;
    for (int n = 0; n < 40; n++) begin
      clear_inputs();
      m = $urandom_range(0, 2);
      hit = 1'($urandom);
      addr = hit ? hit_addr() : miss_addr();
      t = $urandom_range(0, 2);
      op = (t == 0) ? 3'd0 : (t == 1) ? 3'd1 : 3'd4;
      dat = $urandom;
      src = 2'($urandom);
      set_a(m, op, addr, dat, src);
      s_a_ready = 1'b1;
      settle();
      checks++;
      if (s_a_valid !== hit || m_a_ready !== 3'(1 << m) ||
          (hit && (s_a_source !== {2'(m), src} || s_a_address !== addr || s_a_data !== dat))) begin
        errors++;
        $display("FAIL rand_a_%0d: sv %b ready %b src %b addr %h exp hit %b m %0d", n,
                 s_a_valid, m_a_ready, s_a_source, s_a_address, hit, m);
      end
      tick();
      m_ptr = (m + 1) % 3;
      clear_inputs();
      if (!hit) begin
        settle();
        exp_op = (op == 3'd4) ? 3'd1 : 3'd0;
        checks++;
        if (m_d_valid !== 3'(1 << m) || m_d_opcode[m*3 +: 3] !== exp_op ||
            m_d_source[m*2 +: 2] !== src || m_d_error !== 3'(1 << m)) begin
          errors++;
          $display("FAIL rand_err_%0d: v %b op %0d src %0d exp m %0d op %0d src %0d", n,
                   m_d_valid, m_d_opcode[m*3 +: 3], m_d_source[m*2 +: 2], m, exp_op, src);
        end
        m_d_ready[m] = 1'b1;
        tick();
        clear_inputs();
      end
      t = $urandom_range(0, 3);
      rdy = 3'($urandom);
      s_d_valid = 1'b1; s_d_source = {2'(t), 2'($urandom)}; s_d_data = $urandom;
      m_d_ready = rdy;
      settle();
      exp_v = (t < 3) ? 3'(1 << t) : 3'b000;
      exp_sr = (t < 3) ? rdy[t] : 1'b1;
      checks++;
      if (m_d_valid !== exp_v || s_d_ready !== exp_sr) begin
        errors++;
        $display("FAIL rand_d_%0d: v %b sready %b exp %b %b", n, m_d_valid, s_d_ready, exp_v,
                 exp_sr);
      end
      tick();
      clear_inputs();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_get_miss();
    test_put_hit();
    test_contention();
    test_backpressure();
    test_d_collision();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
